// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and parity mode.
package uart_pkg;

    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned OVERSAMPLE  = 16;
    localparam int unsigned SAMPLE_TICK = OVERSAMPLE / 2;
    // 0 selects even parity, 1 would select odd.
    localparam logic        PARITY_ODD  = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_e;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] i_data);
        return (^i_data) ^ PARITY_ODD;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-cycle pulse every CLOCK_RATE/(BAUD_RATE*16) clocks.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 200_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int unsigned DIV = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    // i_clear restarts the phase so the first tick lands DIV cycles later.
    always_ff @(posedge clk) begin
        if (rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/uart_interface.sv
// 8E1 UART with independent TX and RX FSMs, 16x oversampled, mid-bit RX sampling.
module uart_interface
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 200_000_000,
    parameter int unsigned BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data_in,
    input  logic       rx_serial_in,
    output logic       tx_serial_out,
    output logic [7:0] rx_data_out,
    output logic       rx_ready,
    output logic       parity_error,
    output logic       tx_busy
);

    logic w_tx_tick, w_tx_clear, w_rx_tick, w_rx_clear;

    uart_baud_gen #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) u_tx_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_tx_clear),
        .o_tick (w_tx_tick)
    );

    uart_baud_gen #(.CLOCK_RATE(CLOCK_RATE), .BAUD_RATE(BAUD_RATE)) u_rx_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clear(w_rx_clear),
        .o_tick (w_rx_tick)
    );

    // ---------------- Transmitter ----------------
    uart_state_e r_tx_state, w_tx_state;
    logic [7:0]  r_tx_data, w_tx_data;
    logic [2:0]  r_tx_bit, w_tx_bit;
    logic [3:0]  r_tx_tick_cnt, w_tx_tick_cnt;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_tx_state    <= StIdle;
            r_tx_data     <= '0;
            r_tx_bit      <= '0;
            r_tx_tick_cnt <= '0;
        end else begin
            r_tx_state    <= w_tx_state;
            r_tx_data     <= w_tx_data;
            r_tx_bit      <= w_tx_bit;
            r_tx_tick_cnt <= w_tx_tick_cnt;
        end
    end

    always_comb begin
        w_tx_state    = r_tx_state;
        w_tx_data     = r_tx_data;
        w_tx_bit      = r_tx_bit;
        w_tx_tick_cnt = r_tx_tick_cnt;
        w_tx_clear    = 1'b0;
        if (r_tx_state == StIdle) begin
            w_tx_tick_cnt = '0;
            w_tx_bit      = '0;
            if (tx_start) begin
                w_tx_state = StStart;
                w_tx_data  = tx_data_in;
                w_tx_clear = 1'b1;
            end
        end else if (w_tx_tick) begin
            w_tx_tick_cnt = r_tx_tick_cnt + 4'd1;
            if (r_tx_tick_cnt == 4'(OVERSAMPLE - 1)) begin
                unique case (r_tx_state)
                    StStart:  w_tx_state = StData;
                    StData: begin
                        w_tx_bit = r_tx_bit + 3'd1;
                        if (r_tx_bit == 3'(DATA_BITS - 1)) begin
                            w_tx_state = StParity;
                        end
                    end
                    StParity: w_tx_state = StStop;
                    default:  w_tx_state = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        tx_busy = (r_tx_state != StIdle);
        unique case (r_tx_state)
            StStart:  tx_serial_out = 1'b0;
            StData:   tx_serial_out = r_tx_data[r_tx_bit];
            StParity: tx_serial_out = parity_of(r_tx_data);
            default:  tx_serial_out = 1'b1;
        endcase
    end

    // ---------------- Receiver ----------------
    logic r_rx_meta, r_rx_sync, r_rx_prev;
    logic w_rx_fall;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx_serial_in;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_rx_fall = r_rx_prev && !r_rx_sync;

    uart_state_e r_rx_state, w_rx_state;
    logic [3:0]  r_rx_tick_cnt, w_rx_tick_cnt;
    logic [2:0]  r_rx_bit, w_rx_bit;
    logic [7:0]  r_rx_shift, w_rx_shift;
    logic        r_rx_par, w_rx_par;
    logic [7:0]  r_rx_data, w_rx_data;
    logic        r_rx_perr, w_rx_perr;
    logic        r_rx_ready, w_rx_ready;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rx_state    <= StIdle;
            r_rx_tick_cnt <= '0;
            r_rx_bit      <= '0;
            r_rx_shift    <= '0;
            r_rx_par      <= 1'b0;
            r_rx_data     <= '0;
            r_rx_perr     <= 1'b0;
            r_rx_ready    <= 1'b0;
        end else begin
            r_rx_state    <= w_rx_state;
            r_rx_tick_cnt <= w_rx_tick_cnt;
            r_rx_bit      <= w_rx_bit;
            r_rx_shift    <= w_rx_shift;
            r_rx_par      <= w_rx_par;
            r_rx_data     <= w_rx_data;
            r_rx_perr     <= w_rx_perr;
            r_rx_ready    <= w_rx_ready;
        end
    end

    always_comb begin
        w_rx_state    = r_rx_state;
        w_rx_tick_cnt = r_rx_tick_cnt;
        w_rx_bit      = r_rx_bit;
        w_rx_shift    = r_rx_shift;
        w_rx_par      = r_rx_par;
        w_rx_data     = r_rx_data;
        w_rx_perr     = r_rx_perr;
        w_rx_ready    = 1'b0;
        w_rx_clear    = 1'b0;
        if (r_rx_state == StIdle) begin
            w_rx_tick_cnt = '0;
            w_rx_bit      = '0;
            if (w_rx_fall) begin
                w_rx_state = StStart;
                w_rx_clear = 1'b1;
            end
        end else if (w_rx_tick) begin
            w_rx_tick_cnt = r_rx_tick_cnt + 4'd1;
            if (r_rx_tick_cnt == 4'(SAMPLE_TICK - 1)) begin
                // Mid-bit sample point.
                unique case (r_rx_state)
                    StStart: begin
                        if (r_rx_sync) w_rx_state = StIdle;
                    end
                    StData:   w_rx_shift = {r_rx_sync, r_rx_shift[7:1]};
                    StParity: w_rx_par = r_rx_sync;
                    default: begin
                        w_rx_state = StIdle;
                        if (r_rx_sync) begin
                            w_rx_ready = 1'b1;
                            w_rx_data  = r_rx_shift;
                            w_rx_perr  = (r_rx_par != parity_of(r_rx_shift));
                        end
                    end
                endcase
            end else if (r_rx_tick_cnt == 4'(OVERSAMPLE - 1)) begin
                unique case (r_rx_state)
                    StStart:  w_rx_state = StData;
                    StData: begin
                        w_rx_bit = r_rx_bit + 3'd1;
                        if (r_rx_bit == 3'(DATA_BITS - 1)) begin
                            w_rx_state = StParity;
                        end
                    end
                    StParity: w_rx_state = StStop;
                    default:  w_rx_state = StIdle;
                endcase
            end
        end
    end

    assign rx_data_out  = r_rx_data;
    assign rx_ready     = r_rx_ready;
    assign parity_error = r_rx_perr;

endmodule

// File: tb/tb_uart_interface.sv
// Scoreboard bench for uart_interface at a reduced clock/baud ratio to keep runtime short.
module tb_uart_interface;

    localparam int unsigned CLK_HZ = 2_000_000;
    localparam int unsigned BAUD   = 11_520;
    localparam int DIV    = CLK_HZ / (BAUD * 16);
    localparam int BIT    = DIV * 16;
    localparam int FRAME  = BIT * 11;
    // 300 cycles against a 1728-cycle bit, scaled to this bit period.
    localparam int GLITCH = BIT * 300 / 1728;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_start;
    logic [7:0] tx_data_in;
    logic       rx_serial_in;
    logic       tx_serial_out;
    logic [7:0] rx_data_out;
    logic       rx_ready;
    logic       parity_error;
    logic       tx_busy;

    logic loop_en = 1'b0;
    logic loop_q  = 1'b1;
    logic rx_drive = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) loop_q <= tx_serial_out;
    assign rx_serial_in = loop_en ? loop_q : rx_drive;

    uart_interface #(.CLOCK_RATE(CLK_HZ), .BAUD_RATE(BAUD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_start     (tx_start),
        .tx_data_in   (tx_data_in),
        .rx_serial_in (rx_serial_in),
        .tx_serial_out(tx_serial_out),
        .rx_data_out  (rx_data_out),
        .rx_ready     (rx_ready),
        .parity_error (parity_error),
        .tx_busy      (tx_busy)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
    } rx_exp_t;

    rx_exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int rx_cnt   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Monitor: every rx_ready pulse is matched against the oldest expected byte.
    initial begin
        rx_exp_t e;
        logic    rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_ready) begin
                rx_cnt++;
                check_eq("rx_ready_single_cycle", 32'(rdy_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("rx_unexpected_byte", 32'(rx_data_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rx_data", 32'(rx_data_out), 32'(e.data));
                    check_eq("rx_parity_error", 32'(parity_error), 32'(e.perr));
                end
            end
            rdy_prev = rx_ready;
        end
    end

    // Sends a byte on tx and checks the line every cycle against the expected frame.
    task automatic tx_frame_check(input string tag, input logic [7:0] d, input int hold);
        logic [10:0] bits;
        logic        exp_line;
        int          bad_line, busy_cycles;
        bits = {1'b1, (^d), d, 1'b0};
        bad_line = 0;
        busy_cycles = 0;
        @(negedge clk);
        tx_data_in = d;
        tx_start   = 1'b1;
        for (int k = 0; k <= FRAME; k++) begin
            @(negedge clk);
            exp_line = (k < FRAME) ? bits[k / BIT] : 1'b1;
            if (tx_serial_out !== exp_line) bad_line++;
            if (tx_busy) busy_cycles++;
            if (k == 0) tx_data_in = ~d;
            if (k == hold - 1) tx_start = 1'b0;
        end
        tx_start = 1'b0;
        check_eq({tag, "_line_errors"}, 32'(bad_line), 32'd0);
        check_eq({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(FRAME));
    endtask

    task automatic rx_send(input logic [7:0] d, input logic flip, input logic stop);
        logic [10:0] bits;
        rx_exp_t     e;
        bits = {stop, (^d) ^ flip, d, 1'b0};
        if (stop) begin
            e.data = d;
            e.perr = flip;
            exp_q.push_back(e);
        end
        for (int b = 0; b < 11; b++) begin
            rx_drive = bits[b];
            repeat (BIT) @(negedge clk);
        end
        rx_drive = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tx_idle(input int limit);
        int n;
        n = 0;
        while (tx_busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) check_eq("tx_idle_timeout", 32'(n), 32'(limit - 1));
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] hello [13];
        int         snap;
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                  8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
        rst_n      = 1'b1;
        tx_start   = 1'b0;
        tx_data_in = 8'h00;
        repeat (4) @(negedge clk);
        check_eq("rst_tx_line", 32'(tx_serial_out), 32'd1);
        check_eq("rst_tx_busy", 32'(tx_busy), 32'd0);
        check_eq("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_eq("rst_parity_error", 32'(parity_error), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data_out), 32'd0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // TX waveform of 0x48 with a concurrent, independent RX frame.
        fork
            tx_frame_check("tx_48", 8'h48, 10);
            rx_send(8'hC3, 1'b0, 1'b1);
        join
        wait_drain("concurrent", 2 * BIT);

        // Loopback, back-to-back "Hello, World!".
        loop_en = 1'b1;
        snap = rx_cnt;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            rx_exp_t e;
            e.data = hello[i];
            e.perr = 1'b0;
            exp_q.push_back(e);
            wait_tx_idle(FRAME + BIT);
            tx_data_in = hello[i];
            tx_start   = 1'b1;
            @(negedge clk);
            tx_start   = 1'b0;
            @(negedge clk);
        end
        wait_tx_idle(FRAME + BIT);
        wait_drain("hello", 2 * BIT);
        check_eq("hello_byte_count", 32'(rx_cnt - snap), 32'd13);
        loop_en = 1'b0;
        repeat (BIT) @(negedge clk);

        // Parity error, then a framing error that must leave everything untouched.
        rx_send(8'h48, 1'b1, 1'b1);
        repeat (BIT) @(negedge clk);
        check_eq("perr_held", 32'(parity_error), 32'd1);
        snap = rx_cnt;
        rx_send(8'h5A, 1'b0, 1'b0);
        repeat (2 * BIT) @(negedge clk);
        check_eq("framing_no_ready", 32'(rx_cnt), 32'(snap));
        check_eq("framing_data_held", 32'(rx_data_out), 32'h48);
        check_eq("framing_perr_held", 32'(parity_error), 32'd1);
        rx_send(8'h41, 1'b0, 1'b1);
        repeat (BIT) @(negedge clk);
        check_eq("perr_cleared", 32'(parity_error), 32'd0);
        check_eq("data_41", 32'(rx_data_out), 32'h41);

        // Short low glitch on idle line is rejected; receiver still accepts a frame.
        snap = rx_cnt;
        rx_drive = 1'b0;
        repeat (GLITCH) @(negedge clk);
        rx_drive = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check_eq("glitch_no_ready", 32'(rx_cnt), 32'(snap));
        rx_send(8'h7E, 1'b0, 1'b1);
        wait_drain("after_glitch", 2 * BIT);
        check_eq("after_glitch_data", 32'(rx_data_out), 32'h7E);

        // One-cycle reset mid-transmit, with the partial frame looped into RX.
        loop_en = 1'b1;
        @(negedge clk);
        tx_data_in = 8'hA5;
        tx_start   = 1'b1;
        @(negedge clk);
        tx_start   = 1'b0;
        repeat (3 * BIT) @(negedge clk);
        snap  = rx_cnt;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        check_eq("midrst_tx_line", 32'(tx_serial_out), 32'd1);
        check_eq("midrst_tx_busy", 32'(tx_busy), 32'd0);
        repeat (2 * BIT) @(negedge clk);
        check_eq("midrst_no_ready", 32'(rx_cnt), 32'(snap));
        begin
            rx_exp_t e;
            e.data = 8'h3C;
            e.perr = 1'b0;
            exp_q.push_back(e);
        end
        tx_frame_check("tx_after_rst", 8'h3C, 1);
        wait_drain("after_rst", 2 * BIT);
        loop_en = 1'b0;

        repeat (10) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_interface.md
UART_INTERFACE -- requirements
Module: uart_interface

Interface
REQ-001 The block SHALL have parameter CLOCK_RATE, default 200_000_000, giving the system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, giving the serial bit rate in baud.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous, active-high reset (asserted when 1, sampled on the clk rising edge).
REQ-005 The block SHALL have port tx_start, input, 1 bit: request to transmit tx_data_in; level-sensitive.
REQ-006 The block SHALL have port tx_data_in, input, 8 bits: byte to transmit, captured on acceptance.
REQ-007 The block SHALL have port rx_serial_in, input, 1 bit: asynchronous serial receive line, idle high.
REQ-008 The block SHALL have port tx_serial_out, output, 1 bit: serial transmit line, idle high.
REQ-009 The block SHALL have port rx_data_out, output, 8 bits: last received byte, held until the next valid frame.
REQ-010 The block SHALL have port rx_ready, output, 1 bit: one-cycle pulse when rx_data_out is updated.
REQ-011 The block SHALL have port parity_error, output, 1 bit: parity status of the last received frame, held.
REQ-012 The block SHALL have port tx_busy, output, 1 bit: high while the transmitter is not idle.

Function
REQ-013 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of the data bits), 1 stop bit (1); 11 bits total.
REQ-014 Oversample tick SHALL be a one-cycle pulse every DIV = CLOCK_RATE/(BAUD_RATE*16) cycles, integer truncation (108 at defaults); one bit period = 16 ticks (1728 cycles at defaults).
REQ-015 TX states SHALL be IDLE, START, DATA, PARITY, STOP; it SHALL return from STOP to IDLE.
REQ-016 In IDLE with tx_start=1, TX SHALL latch tx_data_in, assert tx_busy on the next cycle and drive the start bit; the tick phase restarts at acceptance.
REQ-017 tx_start SHALL be ignored while tx_busy=1; a tx_start still high after STOP completes starts a new frame.
REQ-018 tx_busy SHALL deassert in the cycle after the stop bit's 16th tick; tx_serial_out SHALL be 1 in IDLE.
REQ-019 rx_serial_in SHALL pass through a 2-flop synchronizer before any use.
REQ-020 RX states SHALL be IDLE, START, DATA, PARITY, STOP; a falling edge in IDLE enters START.
REQ-021 RX SHALL sample each bit at tick 8 of its bit period (mid-bit); a start bit sampled high SHALL return RX to IDLE (glitch rejection).
REQ-022 On a stop bit sampled 1, RX SHALL update rx_data_out, set parity_error = (received parity != even parity of data) and pulse rx_ready high for exactly one cycle.
REQ-023 On a stop bit sampled 0 (framing error), RX SHALL discard the frame: no rx_ready pulse, and rx_data_out and parity_error unchanged.
REQ-024 RX SHALL return to IDLE after the stop-bit sample and SHALL accept a new start edge immediately after.
REQ-025 TX and RX SHALL be fully independent; simultaneous transmit and receive SHALL be supported.

Reset
REQ-026 While rst_n=1, the block SHALL set tx_serial_out=1, tx_busy=0, rx_ready=0, parity_error=0, rx_data_out=8'h00, both FSMs to IDLE, and the tick counter and synchronizer flops to idle/1.
REQ-027 Reset asserted mid-frame SHALL abort the frame at once; a partial RX frame SHALL produce no rx_ready.

Structure
REQ-028 Package uart_pkg SHALL hold the TX/RX state enum typedef, the frame constants (DATA_BITS=8, OVERSAMPLE=16) and the parity mode constant (even).
REQ-029 One sub-module, uart_baud_gen, SHALL generate the oversample tick (parameters CLOCK_RATE, BAUD_RATE); the TX and RX FSMs SHALL live in uart_interface.

Verification
REQ-030 Drive 8'h48 with tx_start held for 10 cycles: tx_serial_out SHALL be low for 1728 cycles (start), then bits 0,0,0,1,0,0,1,0, parity 0, stop 1; tx_busy SHALL be high for 11*1728 cycles.
REQ-031 Loop tx_serial_out to rx_serial_in (one-flop delay) and send "Hello, World!" (13 bytes) back-to-back: 13 single-cycle rx_ready pulses with bytes 0x48,0x65,...,0x21 in order, parity_error=0 throughout.
REQ-032 Inject 8'h48 with the parity bit forced to 1: rx_ready SHALL pulse, rx_data_out=8'h48, parity_error=1; a following correct 8'h41 SHALL clear parity_error to 0.
REQ-033 Inject a frame with stop bit 0: no rx_ready pulse, and rx_data_out and parity_error unchanged.
REQ-034 Inject a 300-cycle low glitch on the idle RX line: no rx_ready pulse, and RX back in IDLE.
REQ-035 Assert rst_n for one cycle mid-transmit: tx_serial_out=1 and tx_busy=0 on the next cycle, and a new tx_start SHALL transmit a full, correct frame.
